cycle_term: RTL and testbench
=============================

# cycle_term

Bus-cycle terminator sitting directly downstream of `fastmem` and the IDE decoder on the TF328 CPU side. It consumes the active-low access/ready qualifiers those blocks produce and returns 68020 dynamic-bus-sizing acknowledges (DSACK) with per-target wait states. It generates IDE read/write strobes and asserts BERR when a claimed cycle never becomes ready.

## Interface
Parameters:
- RAM_WS, 0: extra clocks after RAM_WAIT low before DSACK.
- Z2_WS, 1: extra clocks for autoconfig nibble cycles.
- IDE_WS, 4: extra clocks of IDE strobe before DSACK.
- TIMEOUT, 255: clocks in a claimed cycle before BERR; counter width is clog2(TIMEOUT+1).

Ports:
- CLKCPU  in  1  CPU clock. All logic is on posedge.
- RESET  in  1  reset; asynchronous, active-low.
- AS20  in  1  CPU address strobe, active-low.
- RW20  in  1  1 = read, 0 = write.
- RAM_ACCESS  in  1  active-low; fastmem claims the cycle.
- RAM_WAIT  in  1  active-low; fastmem CAS issued, data valid.
- Z2_ACCESS  in  1  active-low; autoconfig register cycle.
- IDE_ACCESS  in  1  active-low; IDE window cycle.
- DSACK  out  2  active-low acknowledge, [1:0].
- BERR  out  1  active-low bus error.
- IDE_RD  out  1  active-low IDE read strobe.
- IDE_WR  out  1  active-low IDE write strobe.

## Operation
- Target priority when several qualifiers are low: RAM > Z2 > IDE.
- Port width encoding on DSACK[1:0]:
  - RAM (32-bit): 2'b00.
  - Z2 (8-bit): 2'b10.
  - IDE (16-bit): 2'b01.
- States: IDLE, DECODE, READY, COUNT, ACK, BERR, HOLD.
- IDLE: when AS20 = 0 is sampled, go to DECODE. Clear the wait and timeout counters.
- DECODE: latch the target.
  - RAM goes to READY.
  - Z2 or IDE loads wait = Z2_WS or IDE_WS and goes to COUNT.
  - No qualifier low: go to HOLD. No ack is driven; a motherboard device terminates the cycle.
- READY (RAM only): wait for RAM_WAIT = 0, then load wait = RAM_WS and go to COUNT.
- COUNT: if wait = 0, go to ACK; otherwise decrement wait.
- ACK: drive DSACK with the latched width code and hold it until AS20 negates. Then go to IDLE.
- BERR: when the timeout counter reaches TIMEOUT in READY or COUNT, go to BERR. Assert BERR = 0 and keep DSACK = 2'b11 until AS20 negates.
- HOLD: wait for AS20 = 1, then go to IDLE.
- IDE strobes:
  - IDE_RD = 0 when the latched target is IDE and RW20 = 1, from the posedge entering COUNT through ACK.
  - IDE_WR is the same with RW20 = 0.
  - Both negate when the state leaves ACK or BERR.
- AS20 negation in any state:
  - DSACK, BERR, IDE_RD and IDE_WR are forced high combinationally (registered value OR AS20).
  - The state returns to IDLE on the next posedge. This covers an aborted cycle mid-COUNT.

## Timing
- Reset values: DSACK = 2'b11, BERR = 1, IDE_RD = 1, IDE_WR = 1, state IDLE, counters 0.
- RAM latency: DSACK asserts RAM_WS+1 posedges after the first posedge sampling RAM_WAIT = 0. With RAM_WS = 0, that is one posedge.
- Z2/IDE latency: DSACK asserts (WS+2) posedges after the DECODE posedge.
- Timeout counter:
  - Increments each posedge in READY and COUNT.
  - Saturates; it never wraps.
  - BERR asserts on the posedge after it equals TIMEOUT.
- Simultaneous events:
  - If RAM_WAIT = 0 and the timeout is reached on the same posedge, ack wins.
  - If AS20 = 1 and a state transition are sampled on the same edge, the state goes to IDLE.
- Reset mid-cycle: all outputs go to reset values immediately; the state is IDLE.
- Back-to-back cycles: a new cycle needs AS20 high for at least one posedge. A strobe held low from ACK never starts a second cycle.

## Structure
- Shared package `tf328_pkg` holds:
  - State encodings, as localparams.
  - Width codes DSACK_32 = 2'b00, DSACK_16 = 2'b01, DSACK_8 = 2'b10, DSACK_NONE = 2'b11.
  - Target codes TGT_NONE, TGT_RAM, TGT_Z2, TGT_IDE.
- One natural sub-module: `ws_counter`, a loadable down-counter with zero flag. Instantiate it for the wait counter. The timeout counter is inline.

## Test plan
- RAM read, RAM_WS = 0: AS20 low, RAM_ACCESS low, RAM_WAIT low 2 clocks later -> DSACK = 00 one posedge after RAM_WAIT low; DSACK = 11 same cycle AS20 rises.
- Z2 read, Z2_WS = 1: Z2_ACCESS low -> DSACK = 10 at the 3rd posedge after DECODE; IDE strobes stay high.
- IDE write, IDE_WS = 4: IDE_ACCESS low, RW20 = 0 -> IDE_WR low from the COUNT entry for 6 clocks; DSACK = 01 on the 6th posedge after DECODE; IDE_RD stays 1.
- Timeout, TIMEOUT = 15: RAM_ACCESS low, RAM_WAIT held high -> BERR = 0 at posedge 17 after DECODE; DSACK stays 11; BERR releases when AS20 rises.
- Priority/abort: RAM_ACCESS and IDE_ACCESS both low -> DSACK = 00, no IDE strobe. Separately, IDE cycle with AS20 raised mid-COUNT -> strobes high immediately, state IDLE next posedge, no DSACK.
- Async reset during ACK: RESET low -> DSACK = 11 and BERR = 1 without a clock edge; next cycle after RESET release terminates normally.

Source files
------------

// File: rtl/tf328_pkg.sv
// Shared TF328 CPU-side definitions: bus-cycle states, target codes and
// 68020 DSACK port-width encodings.
package tf328_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READY,
        ST_COUNT,
        ST_ACK,
        ST_BERR,
        ST_HOLD
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_RAM,
        TGT_Z2,
        TGT_IDE
    } tgt_t;

    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    function automatic logic [1:0] dsack_code(input tgt_t tgt);
        case (tgt)
            TGT_RAM: return DSACK_32;
            TGT_Z2:  return DSACK_8;
            TGT_IDE: return DSACK_16;
            default: return DSACK_NONE;
        endcase
    endfunction

endpackage

// File: rtl/cycle_term_ws_counter.sv
// Loadable wait-state down-counter; holds at zero and flags it.
module ws_counter
    import tf328_pkg::*;
#(
    parameter int unsigned W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cycle_term.sv
// TF328 bus-cycle terminator: DSACK with per-target wait states, IDE strobes
// and BERR on a claimed cycle that never becomes ready.
module cycle_term
    import tf328_pkg::*;
#(
    parameter int unsigned RAM_WS  = 0,
    parameter int unsigned Z2_WS   = 1,
    parameter int unsigned IDE_WS  = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       CLKCPU,
    input  logic       RESET,
    input  logic       AS20,
    input  logic       RW20,
    input  logic       RAM_ACCESS,
    input  logic       RAM_WAIT,
    input  logic       Z2_ACCESS,
    input  logic       IDE_ACCESS,
    output logic [1:0] DSACK,
    output logic       BERR,
    output logic       IDE_RD,
    output logic       IDE_WR
);

    localparam int unsigned WS_MAX0 = (RAM_WS > Z2_WS) ? RAM_WS : Z2_WS;
    localparam int unsigned WS_MAX  = (WS_MAX0 > IDE_WS) ? WS_MAX0 : IDE_WS;
    localparam int unsigned WS_W    = (WS_MAX < 1) ? 1 : $clog2(WS_MAX + 1);
    localparam int unsigned TMO_W   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_t          r_state;
    tgt_t            r_tgt;
    logic [1:0]      r_dsack;
    logic            r_berr;
    logic            r_ide_rd;
    logic            r_ide_wr;
    logic [TMO_W-1:0] r_tmo;

    tgt_t            w_tgt;
    logic            w_ws_load;
    logic [WS_W-1:0] w_ws_val;
    logic            w_ws_dec;
    logic            w_ws_zero;
    logic            w_tmo_hit;

    always_comb begin
        if (!RAM_ACCESS)      w_tgt = TGT_RAM;
        else if (!Z2_ACCESS)  w_tgt = TGT_Z2;
        else if (!IDE_ACCESS) w_tgt = TGT_IDE;
        else                  w_tgt = TGT_NONE;
    end

    always_comb begin
        w_ws_load = 1'b0;
        w_ws_val  = '0;
        w_ws_dec  = 1'b0;
        case (r_state)
            ST_IDLE: w_ws_load = 1'b1;
            ST_DECODE: begin
                w_ws_load = 1'b1;
                if (w_tgt == TGT_Z2)       w_ws_val = WS_W'(Z2_WS);
                else if (w_tgt == TGT_IDE) w_ws_val = WS_W'(IDE_WS);
            end
            ST_READY: begin
                w_ws_load = !RAM_WAIT;
                w_ws_val  = WS_W'(RAM_WS);
            end
            ST_COUNT: w_ws_dec = 1'b1;
            default: ;
        endcase
    end

    ws_counter #(.W(WS_W)) u_ws (
        .i_clk   (CLKCPU),
        .i_rst_n (RESET),
        .i_load  (w_ws_load),
        .i_val   (w_ws_val),
        .i_dec   (w_ws_dec),
        .o_zero  (w_ws_zero)
    );

    assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT));

    // AS20 negation takes precedence over every state transition.
    always_ff @(posedge CLKCPU or negedge RESET) begin
        if (!RESET) begin
            r_state  <= ST_IDLE;
            r_tgt    <= TGT_NONE;
            r_dsack  <= DSACK_NONE;
            r_berr   <= 1'b1;
            r_ide_rd <= 1'b1;
            r_ide_wr <= 1'b1;
            r_tmo    <= '0;
        end else if (AS20) begin
            r_state  <= ST_IDLE;
            r_dsack  <= DSACK_NONE;
            r_berr   <= 1'b1;
            r_ide_rd <= 1'b1;
            r_ide_wr <= 1'b1;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tmo   <= '0;
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_tgt <= w_tgt;
                    case (w_tgt)
                        TGT_RAM: r_state <= ST_READY;
                        TGT_Z2:  r_state <= ST_COUNT;
                        TGT_IDE: begin
                            r_state  <= ST_COUNT;
                            r_ide_rd <= !RW20;
                            r_ide_wr <= RW20;
                        end
                        default: r_state <= ST_HOLD;
                    endcase
                end
                ST_READY: begin
                    if (!RAM_WAIT) begin
                        r_state <= ST_COUNT;
                    end else if (w_tmo_hit) begin
                        r_state <= ST_BERR;
                        r_berr  <= 1'b0;
                    end
                    if (!w_tmo_hit) r_tmo <= r_tmo + TMO_W'(1);
                end
                ST_COUNT: begin
                    if (w_ws_zero) begin
                        r_state <= ST_ACK;
                        r_dsack <= dsack_code(r_tgt);
                    end else if (w_tmo_hit) begin
                        r_state <= ST_BERR;
                        r_berr  <= 1'b0;
                    end
                    if (!w_tmo_hit) r_tmo <= r_tmo + TMO_W'(1);
                end
                ST_ACK, ST_BERR, ST_HOLD: r_state <= r_state;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign DSACK  = r_dsack | {2{AS20}};
    assign BERR   = r_berr | AS20;
    assign IDE_RD = r_ide_rd | AS20;
    assign IDE_WR = r_ide_wr | AS20;

endmodule

// File: tb/tb_cycle_term.sv
// Scoreboard bench for cycle_term: expected {DSACK,BERR,IDE_RD,IDE_WR} per cycle.
module tb_cycle_term;

    logic       CLKCPU = 1'b0;
    logic       RESET = 1'b0;
    logic       AS20 = 1'b1;
    logic       RW20 = 1'b1;
    logic       RAM_ACCESS = 1'b1;
    logic       RAM_WAIT = 1'b1;
    logic       Z2_ACCESS = 1'b1;
    logic       IDE_ACCESS = 1'b1;
    logic [1:0] DSACK;
    logic       BERR;
    logic       IDE_RD;
    logic       IDE_WR;
    logic [4:0] w_obs;

    int n_checks = 0;
    int n_fail   = 0;
    logic [4:0] exp_q[$];
    string      tag_q[$];

    localparam logic [4:0] OUT_IDLE = 5'b11111;

    always #5 CLKCPU = ~CLKCPU;

    cycle_term #(
        .RAM_WS  (0),
        .Z2_WS   (1),
        .IDE_WS  (4),
        .TIMEOUT (15)
    ) dut (
        .CLKCPU     (CLKCPU),
        .RESET      (RESET),
        .AS20       (AS20),
        .RW20       (RW20),
        .RAM_ACCESS (RAM_ACCESS),
        .RAM_WAIT   (RAM_WAIT),
        .Z2_ACCESS  (Z2_ACCESS),
        .IDE_ACCESS (IDE_ACCESS),
        .DSACK      (DSACK),
        .BERR       (BERR),
        .IDE_RD     (IDE_RD),
        .IDE_WR     (IDE_WR)
    );

    assign w_obs = {DSACK, BERR, IDE_RD, IDE_WR};

    task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got {DSACK,BERR,RD,WR}=%b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp(input string tag, input logic [4:0] exp);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check();
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: got output %b expected a queued entry", w_obs);
        end else begin
            chk(tag_q.pop_front(), w_obs, exp_q.pop_front());
        end
    endtask

    // One posedge, then compare 1ns later.
    task automatic cyc(input string tag, input logic [4:0] exp);
        push_exp(tag, exp);
        @(posedge CLKCPU);
        #1;
        pop_check();
    endtask

    // Combinational check without a clock edge.
    task automatic now_check(input string tag, input logic [4:0] exp);
        push_exp(tag, exp);
        #1;
        pop_check();
    endtask

    task automatic z2_cycle(input string pfx);
        AS20 = 1'b0; Z2_ACCESS = 1'b0; RW20 = 1'b1;
        cyc({pfx, "_p0"}, OUT_IDLE);
        cyc({pfx, "_p1"}, OUT_IDLE);
        cyc({pfx, "_p2"}, OUT_IDLE);
        cyc({pfx, "_ack"}, 5'b10111);
        AS20 = 1'b1;
        now_check({pfx, "_rel"}, OUT_IDLE);
        Z2_ACCESS = 1'b1;
        cyc({pfx, "_idle"}, OUT_IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        #2;
        now_check("reset_state", OUT_IDLE);
        @(posedge CLKCPU); #1;
        RESET = 1'b1;
        cyc("post_reset", OUT_IDLE);

        // RAM read, RAM_WAIT low two clocks after the cycle starts
        AS20 = 1'b0; RAM_ACCESS = 1'b0; RW20 = 1'b1;
        cyc("ram_p0", OUT_IDLE);
        cyc("ram_p1", OUT_IDLE);
        RAM_WAIT = 1'b0;
        cyc("ram_wait_seen", OUT_IDLE);
        cyc("ram_ack", 5'b00111);
        AS20 = 1'b1;
        now_check("ram_rel", OUT_IDLE);
        RAM_ACCESS = 1'b1; RAM_WAIT = 1'b1;
        cyc("ram_idle", OUT_IDLE);

        z2_cycle("z2");

        // IDE write
        AS20 = 1'b0; IDE_ACCESS = 1'b0; RW20 = 1'b0;
        cyc("ide_p0", OUT_IDLE);
        for (int i = 0; i < 5; i++) cyc("ide_wr_strobe", 5'b11110);
        cyc("ide_ack", 5'b01110);
        AS20 = 1'b1;
        now_check("ide_rel", OUT_IDLE);
        IDE_ACCESS = 1'b1; RW20 = 1'b1;
        cyc("ide_idle", OUT_IDLE);

        // Timeout: RAM claims but never becomes ready
        AS20 = 1'b0; RAM_ACCESS = 1'b0; RAM_WAIT = 1'b1;
        for (int i = 0; i < 17; i++) cyc("tmo_wait", OUT_IDLE);
        cyc("tmo_berr", 5'b11011);
        cyc("tmo_berr_hold", 5'b11011);
        AS20 = 1'b1;
        now_check("tmo_rel", OUT_IDLE);
        RAM_ACCESS = 1'b1;
        cyc("tmo_idle", OUT_IDLE);

        // Priority: RAM over IDE
        AS20 = 1'b0; RAM_ACCESS = 1'b0; IDE_ACCESS = 1'b0; RW20 = 1'b1; RAM_WAIT = 1'b0;
        cyc("prio_p0", OUT_IDLE);
        cyc("prio_p1", OUT_IDLE);
        cyc("prio_p2", OUT_IDLE);
        cyc("prio_ack", 5'b00111);
        AS20 = 1'b1;
        now_check("prio_rel", OUT_IDLE);
        RAM_ACCESS = 1'b1; IDE_ACCESS = 1'b1; RAM_WAIT = 1'b1;
        cyc("prio_idle", OUT_IDLE);

        // Abort an IDE read mid-COUNT
        AS20 = 1'b0; IDE_ACCESS = 1'b0; RW20 = 1'b1;
        cyc("abort_p0", OUT_IDLE);
        cyc("abort_rd1", 5'b11101);
        cyc("abort_rd2", 5'b11101);
        AS20 = 1'b1;
        now_check("abort_comb", OUT_IDLE);
        IDE_ACCESS = 1'b1;
        cyc("abort_idle", OUT_IDLE);
        z2_cycle("post_abort");

        // Asynchronous reset while acknowledging
        AS20 = 1'b0; RAM_ACCESS = 1'b0; RAM_WAIT = 1'b0;
        cyc("rst_p0", OUT_IDLE);
        cyc("rst_p1", OUT_IDLE);
        cyc("rst_p2", OUT_IDLE);
        cyc("rst_ack", 5'b00111);
        RESET = 1'b0;
        now_check("rst_async", OUT_IDLE);
        AS20 = 1'b1; RAM_ACCESS = 1'b1; RAM_WAIT = 1'b1;
        cyc("rst_held", OUT_IDLE);
        RESET = 1'b1;
        cyc("rst_release", OUT_IDLE);
        z2_cycle("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
